// File: rtl/mem_arbiter.sv
// Two-port arbiter that runs one request at a time against a single-port word memory.
// Define MEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed port-0 priority.
module mem_arbiter #(
    parameter int SIZE = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic        p0_req_we,
    input  logic [31:0] p0_req_addr,
    input  logic [31:0] p0_req_wdata,
    output logic        p0_rsp_valid,
    output logic [31:0] p0_rsp_rdata,
    output logic        p0_rsp_err,
    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic        p1_req_we,
    input  logic [31:0] p1_req_addr,
    input  logic [31:0] p1_req_wdata,
    output logic        p1_rsp_valid,
    output logic [31:0] p1_rsp_rdata,
    output logic        p1_rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_w,
    output logic        mem_r,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] SIZE_W = 32'(SIZE);

    state_t      state_q, state_d;
    logic        lat_we_q;
    logic        lat_id_q;
    logic [31:0] lat_addr_q;
    logic [31:0] lat_wdata_q;
    logic [31:0] rdata_q [2];
    logic        err_q   [2];
    logic        win_id;
    logic        accept;
    logic        in_range;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign win_id = ~p0_req_valid;
`else
    logic last_grant_q;

    always_comb begin
        if (p0_req_valid && p1_req_valid) begin
            win_id = ~last_grant_q;
        end else begin
            win_id = ~p0_req_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= win_id;
        end
    end
`endif

    // Reset blocks acceptance so nothing is latched in the reset cycle.
    assign accept   = (state_q == IDLE) && (p0_req_valid || p1_req_valid) && !reset;
    assign in_range = lat_addr_q < SIZE_W;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lat_we_q    <= 1'b0;
            lat_id_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lat_id_q    <= win_id;
                lat_we_q    <= win_id ? p1_req_we    : p0_req_we;
                lat_addr_q  <= win_id ? p1_req_addr  : p0_req_addr;
                lat_wdata_q <= win_id ? p1_req_wdata : p0_req_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                rdata_q[i] <= '0;
                err_q[i]   <= 1'b0;
            end
        end else if (state_q == ACCESS) begin
            rdata_q[lat_id_q] <= (in_range && !lat_we_q) ? mem_rdata : '0;
            err_q[lat_id_q]   <= !in_range;
        end
    end

    always_comb begin
        state_d      = state_q;
        p0_req_ready = 1'b0;
        p1_req_ready = 1'b0;
        p0_rsp_valid = 1'b0;
        p1_rsp_valid = 1'b0;
        mem_address  = '0;
        mem_data     = '0;
        mem_w        = 1'b0;
        mem_r        = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = ACCESS;
                    p0_req_ready = ~win_id;
                    p1_req_ready = win_id;
                end
            end
            ACCESS: begin
                state_d = RESP;
                // Gating with reset keeps an aborted write from reaching memory.
                if (in_range && !reset) begin
                    mem_address = lat_addr_q;
                    if (lat_we_q) begin
                        mem_w    = 1'b1;
                        mem_data = lat_wdata_q;
                    end else begin
                        mem_r = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                if (!reset) begin
                    p0_rsp_valid = ~lat_id_q;
                    p1_rsp_valid = lat_id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign p0_rsp_rdata = rdata_q[0];
    assign p0_rsp_err   = err_q[0];
    assign p1_rsp_rdata = rdata_q[1];
    assign p1_rsp_err   = err_q[1];
    assign busy         = (state_q != IDLE);

endmodule
